// File: rtl/wf_gather_ctrl_pkg.sv
// Shared parameters and record types for the wavefront gather-count controller.
package wf_gather_ctrl_pkg;

  localparam int NUM_WF  = 16;
  localparam int WF_ID_W = 4;
  localparam int CNT_W   = 3;

  typedef logic [WF_ID_W-1:0] wf_id_t;
  typedef logic [CNT_W-1:0]   cnt_t;

  typedef struct packed {
    wf_id_t wf_id;
  } done_tok_t;

  typedef struct packed {
    logic   valid;
    wf_id_t addr;
    cnt_t   data;
  } fwd_rec_t;

  // A slot with expected == 0 is unallocated and must never complete, even when the count wraps to 0.
  function automatic logic cnt_hits(input cnt_t count, input cnt_t expected);
    return (expected != '0) && (count == expected);
  endfunction

endpackage

// File: rtl/wf_gather_done_fifo.sv
// Small valid/ready FIFO for done tokens; exposes its occupancy so the producer can reserve space upstream.
module wf_gather_done_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 4,
  parameter int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push_valid_i,
  input  logic [W-1:0]  push_data_i,
  output logic          pop_valid_o,
  input  logic          pop_ready_i,
  output logic [W-1:0]  pop_data_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign pop  = (count_q != '0) && pop_ready_i;
  assign push = push_valid_i && (count_q != CW'(DEPTH));

  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign pop_valid_o = (count_q != '0);
  assign pop_data_o  = mem_q[rd_ptr_q];
  assign count_o     = count_q;

endmodule

// File: rtl/wf_gather_ctrl.sv
// Read-modify-write gather-count controller: counts per-wavefront events and emits a done token on reaching the allocated total.
// Optional sticky overflow check built when WF_GATHER_OVERFLOW_CHK_EN is defined.
module wf_gather_ctrl
  import wf_gather_ctrl_pkg::*;
#(
  parameter int OUT_DEPTH = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               alloc_valid,
  output logic               alloc_ready,
  input  logic [WF_ID_W-1:0] alloc_wf_id,
  input  logic [CNT_W-1:0]   alloc_num,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WF_ID_W-1:0] in_wf_id,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WF_ID_W-1:0] out_wf_id,
  output logic               mem_w_en,
  output logic [WF_ID_W-1:0] mem_w_addr,
  output logic [CNT_W-1:0]   mem_w_data,
  output logic               mem_r_en,
  output logic [WF_ID_W-1:0] mem_r_addr,
  input  logic [CNT_W-1:0]   mem_r_data
`ifdef WF_GATHER_OVERFLOW_CHK_EN
  ,
  output logic               err_overflow,
  output logic [WF_ID_W-1:0] err_wf_id
`endif
);

  localparam int FIFO_CW = $clog2(OUT_DEPTH + 1);

  logic                        s1_valid_q, s1_valid_d;
  wf_id_t                      s1_wf_q, s1_wf_d;
  logic                        s1_fwd_hit_q, s1_fwd_hit_d;
  cnt_t                        s1_fwd_data_q, s1_fwd_data_d;
  logic [NUM_WF-1:0][CNT_W-1:0] expected_vec;
  cnt_t                        s1_expected;
  cnt_t                        old_cnt, new_cnt;
  logic                        s1_done;
  logic                        in_fire, alloc_fire;
  fwd_rec_t                    fwd;
  logic [FIFO_CW-1:0]          fifo_count;
  done_tok_t                   push_tok, head_tok;

  // Reserving FIFO space for the S1 occupant guarantees S1 never stalls.
  assign in_ready    = (int'(fifo_count) + int'(s1_valid_q)) < OUT_DEPTH;
  assign alloc_ready = !s1_valid_q;
  assign in_fire     = in_valid && in_ready;
  assign alloc_fire  = alloc_valid && alloc_ready;

  assign mem_r_en   = in_fire;
  assign mem_r_addr = in_wf_id;

  for (genvar gi = 0; gi < NUM_WF; gi++) begin : g_slot
    cnt_t expected_q;
    always_ff @(posedge clock) begin
      if (reset) begin
        expected_q <= '0;
      end else if (alloc_fire && (alloc_wf_id == WF_ID_W'(gi))) begin
        expected_q <= alloc_num;
      end
    end
    assign expected_vec[gi] = expected_q;
  end

  assign s1_expected = expected_vec[s1_wf_q];
  assign old_cnt     = s1_fwd_hit_q ? s1_fwd_data_q : mem_r_data;
  assign new_cnt     = old_cnt + 1'b1;
  assign s1_done     = s1_valid_q && cnt_hits(new_cnt, s1_expected);

  // The single write port goes to S1 first; an alloc only writes when S1 is idle.
  always_comb begin
    fwd = '0;
    if (s1_valid_q) begin
      fwd.valid = 1'b1;
      fwd.addr  = s1_wf_q;
      fwd.data  = s1_done ? '0 : new_cnt;
    end else if (alloc_fire) begin
      fwd.valid = 1'b1;
      fwd.addr  = alloc_wf_id;
      fwd.data  = '0;
    end
  end

  assign mem_w_en   = fwd.valid;
  assign mem_w_addr = fwd.addr;
  assign mem_w_data = fwd.data;

  // The write landing this cycle may collide with the S0 read; capture it so S1 never depends on RAM collision behaviour.
  always_comb begin
    s1_valid_d    = in_fire;
    s1_wf_d       = in_wf_id;
    s1_fwd_hit_d  = fwd.valid && (fwd.addr == in_wf_id);
    s1_fwd_data_d = fwd.data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_q    <= 1'b0;
      s1_wf_q       <= '0;
      s1_fwd_hit_q  <= 1'b0;
      s1_fwd_data_q <= '0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_wf_q       <= s1_wf_d;
      s1_fwd_hit_q  <= s1_fwd_hit_d;
      s1_fwd_data_q <= s1_fwd_data_d;
    end
  end

  assign push_tok = done_tok_t'(s1_wf_q);

  wf_gather_done_fifo #(
    .DEPTH (OUT_DEPTH),
    .W     ($bits(done_tok_t)),
    .CW    (FIFO_CW)
  ) u_done_fifo (
    .clock        (clock),
    .reset        (reset),
    .push_valid_i (s1_done),
    .push_data_i  (push_tok),
    .pop_valid_o  (out_valid),
    .pop_ready_i  (out_ready),
    .pop_data_o   (head_tok),
    .count_o      (fifo_count)
  );

  assign out_wf_id = head_tok.wf_id;

`ifdef WF_GATHER_OVERFLOW_CHK_EN
  logic   err_q, err_d;
  wf_id_t err_wf_q, err_wf_d;
  logic   ovf_hit;

  assign ovf_hit = s1_valid_q && ((s1_expected == '0) || (old_cnt >= s1_expected));

  // Only the first offender is recorded; the flag stays set until reset.
  always_comb begin
    err_d    = err_q;
    err_wf_d = err_wf_q;
    if (ovf_hit && !err_q) begin
      err_d    = 1'b1;
      err_wf_d = s1_wf_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      err_q    <= 1'b0;
      err_wf_q <= '0;
    end else begin
      err_q    <= err_d;
      err_wf_q <= err_wf_d;
    end
  end

  assign err_overflow = err_q;
  assign err_wf_id    = err_wf_q;
`endif

endmodule
